// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master drives requests; the slave (the arbiter) drives the grant.
interface rr_onehot_arbiter_if #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
);
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_idx;
    logic            grant_valid;
    logic            forced;

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, forced
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, forced
    );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with binary and one-hot grant outputs and a hold-time limit.
// A grant is held until done, request drop, or MAX_HOLD consecutive cycles.
module rr_onehot_arbiter #(
    parameter int N        = 8,
    parameter int IDXW     = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_onehot_arbiter_if.slave  bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam int         CW       = 16;
    localparam logic [CW-1:0]   HOLD_LIM = CW'(MAX_HOLD);
    localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
        onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [0:0]      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            forced_q, forced_d;
    logic [N-1:0]    grant_q, grant_d;

    logic [N-1:0]    cand_s;
    logic [IDXW-1:0] pos_s;
    logic [IDXW-1:0] win_s;
    logic            found_s;
    logic            hit_s;
    logic            owner_req_s;
    logic            lim_s;
    logic            rel_s;

    // Round-robin search from last+1, wrapping at N; the owner is masked while granted.
    always_comb begin
        cand_s  = (state_q == ST_GRANT) ? (bus.req & ~grant_q) : bus.req;
        pos_s   = last_q;
        win_s   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s   = (pos_s == IDX_LAST) ? '0 : pos_s + IDXW'(1);
            hit_s   = cand_s[pos_s];
            win_s   = (!found_s && hit_s) ? pos_s : win_s;
            found_s = found_s | hit_s;
        end
    end

    // Release conditions for the current owner.
    always_comb begin
        owner_req_s = bus.req[idx_q];
        lim_s       = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
        rel_s       = bus.done || !owner_req_s || lim_s;
    end

    // Next-state logic: idle/grant FSM with back-to-back handover and owner re-grant.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        forced_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_GRANT;
                    idx_d   = win_s;
                    last_d  = win_s;
                    cnt_d   = CW'(1);
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!rel_s) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                end else begin
                    // Only the hold limit counts as a forced revoke.
                    forced_d = lim_s && !bus.done && owner_req_s;
                    if (found_s) begin
                        idx_d  = win_s;
                        last_d = win_s;
                        cnt_d  = CW'(1);
                    end else if (owner_req_s) begin
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
        grant_d = valid_d ? onehot(idx_d) : '0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            last_q   <= IDX_LAST;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            forced_q <= 1'b0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            forced_q <= forced_d;
            grant_q  <= grant_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.forced      = forced_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: three instances (N=8/MAX_HOLD=16,
// N=8/MAX_HOLD=4, N=5/MAX_HOLD=16) driven with hand-computed vectors.
module tb_rr_onehot_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_onehot_arbiter_if #(.N(8)) bus_a();
    rr_onehot_arbiter_if #(.N(8)) bus_b();
    rr_onehot_arbiter_if #(.N(5)) bus_c();

    rr_onehot_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    rr_onehot_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    rr_onehot_arbiter #(.N(5), .IDXW(3), .MAX_HOLD(16)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [2:0] idx, input logic vld, input logic frc);
        logic [7:0] g;
        g = vld ? (8'h01 << idx) : 8'h00;
        check_val({tag, ".idx"},    64'(bus_a.grant_idx),   64'(vld ? idx : 3'd0));
        check_val({tag, ".grant"},  64'(bus_a.grant),       64'(g));
        check_val({tag, ".valid"},  64'(bus_a.grant_valid), 64'(vld));
        check_val({tag, ".forced"}, 64'(bus_a.forced),      64'(frc));
    endtask

    task automatic check_b(input string tag, input logic [2:0] idx, input logic vld, input logic frc);
        logic [7:0] g;
        g = vld ? (8'h01 << idx) : 8'h00;
        check_val({tag, ".idx"},    64'(bus_b.grant_idx),   64'(vld ? idx : 3'd0));
        check_val({tag, ".grant"},  64'(bus_b.grant),       64'(g));
        check_val({tag, ".valid"},  64'(bus_b.grant_valid), 64'(vld));
        check_val({tag, ".forced"}, 64'(bus_b.forced),      64'(frc));
    endtask

    task automatic check_c(input string tag, input logic [2:0] idx, input logic vld);
        logic [4:0] g;
        g = vld ? (5'h01 << idx) : 5'h00;
        check_val({tag, ".idx"},   64'(bus_c.grant_idx),   64'(vld ? idx : 3'd0));
        check_val({tag, ".grant"}, 64'(bus_c.grant),       64'(g));
        check_val({tag, ".valid"}, 64'(bus_c.grant_valid), 64'(vld));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus_a.req = 8'h00; bus_a.done = 1'b0;
        bus_b.req = 8'h00; bus_b.done = 1'b0;
        bus_c.req = 5'h00; bus_c.done = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_a("rst_a", 3'd0, 1'b0, 1'b0);
        check_b("rst_b", 3'd0, 1'b0, 1'b0);
        check_c("rst_c", 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, one-cycle latency, release with done.
        bus_a.req = 8'h01;
        tick();
        check_a("single", 3'd0, 1'b1, 1'b0);
        bus_a.done = 1'b1; bus_a.req = 8'h00;
        tick();
        check_a("release", 3'd0, 1'b0, 1'b0);
        bus_a.done = 1'b0;

        // All requesting, done every cycle: 0..7,0 with no bubble.
        do_reset();
        bus_a.req = 8'hFF; bus_a.done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_a($sformatf("rr%0d", k), 3'(k % 8), 1'b1, 1'b0);
        end

        // Wrap-around past 7 back to 0, then 5 again.
        bus_a.req = 8'h20;
        tick();
        check_a("to5", 3'd5, 1'b1, 1'b0);
        bus_a.req = 8'h21;
        tick();
        check_a("wrap0", 3'd0, 1'b1, 1'b0);
        tick();
        check_a("back5", 3'd5, 1'b1, 1'b0);
        bus_a.done = 1'b0; bus_a.req = 8'h24;
        tick();
        check_a("hold5", 3'd5, 1'b1, 1'b0);
        bus_a.req = 8'h04;
        tick();
        check_a("drop5", 3'd2, 1'b1, 1'b0);
        bus_a.req = 8'h00;
        tick();
        check_a("idle", 3'd0, 1'b0, 1'b0);
        bus_a.done = 1'b1;
        tick();
        check_a("done_idle", 3'd0, 1'b0, 1'b0);
        bus_a.done = 1'b0;

        // Hold limit of 4 on instance B.
        bus_b.req = 8'h18;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_b($sformatf("hold%0d", k), 3'd3, 1'b1, 1'b0);
        end
        tick();
        check_b("timeout", 3'd4, 1'b1, 1'b1);
        bus_b.req = 8'h08;
        tick();
        check_b("only3", 3'd3, 1'b1, 1'b0);
        repeat (3) tick();
        check_b("only3_hold", 3'd3, 1'b1, 1'b0);
        tick();
        check_b("regrant", 3'd3, 1'b1, 1'b1);
        tick();
        check_b("regrant_next", 3'd3, 1'b1, 1'b0);
        bus_b.req = 8'h00;
        tick();
        check_b("b_idle", 3'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-grant.
        bus_a.req = 8'hFF;
        tick();
        check_a("pre_rst", 3'd3, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_a("async_rst", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_a("post_rst", 3'd0, 1'b1, 1'b0);
        bus_a.req = 8'h00;

        // N=5: wrap at 5, never 5..7.
        bus_c.req = 5'b10000;
        tick();
        check_c("n5_4", 3'd4, 1'b1);
        bus_c.done = 1'b1; bus_c.req = 5'b10001;
        tick();
        check_c("n5_wrap", 3'd0, 1'b1);
        bus_c.req = 5'b11111;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_c($sformatf("n5_rr%0d", k), 3'(k % 5), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
